// File: rtl/dm4_route.sv
// dm4_route: one input AXI-Stream routed by s_TDEST to four outputs, each with a 2-entry FIFO.
// Optional DM4_ROUTE_DROP_EN adds per-output enable (en) and a dropped-packet counter (drop_cnt).
module dm4_route #(
    parameter int DATA_WIDTH = 32,
    parameter int TLAST_ARB  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_TDATA,
    input  logic                  s_TVALID,
    output logic                  s_TREADY,
    input  logic                  s_TLAST,
    input  logic [1:0]            s_TDEST,
    output logic [DATA_WIDTH-1:0] o0_TDATA,
    output logic                  o0_TVALID,
    input  logic                  o0_TREADY,
    output logic                  o0_TLAST,
    output logic [DATA_WIDTH-1:0] o1_TDATA,
    output logic                  o1_TVALID,
    input  logic                  o1_TREADY,
    output logic                  o1_TLAST,
    output logic [DATA_WIDTH-1:0] o2_TDATA,
    output logic                  o2_TVALID,
    input  logic                  o2_TREADY,
    output logic                  o2_TLAST,
    output logic [DATA_WIDTH-1:0] o3_TDATA,
    output logic                  o3_TVALID,
    input  logic                  o3_TREADY,
    output logic                  o3_TLAST
`ifdef DM4_ROUTE_DROP_EN
    ,
    input  logic [3:0]            en,
    output logic [15:0]           drop_cnt
`endif
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state, state_nx;
    logic [1:0]            dest_r, sel;
    logic                  en_sel, accept;
    logic [3:0]            o_rdy, vld, push, pop;
    logic [3:0]            wr_ptr, rd_ptr;
    logic [1:0]            occ  [4];
    logic [DATA_WIDTH:0]   mem  [4][2];
    logic [DATA_WIDTH:0]   head [4];

    assign o_rdy = {o3_TREADY, o2_TREADY, o1_TREADY, o0_TREADY};

`ifdef DM4_ROUTE_DROP_EN
    logic en_r;
    assign en_sel = (state == LOCKED) ? en_r : en[s_TDEST];
`else
    assign en_sel = 1'b1;
`endif

    // Ready depends only on registered occupancy and the route; gating with rst keeps it low in reset.
    always_comb begin
        sel      = (state == LOCKED) ? dest_r : s_TDEST;
        s_TREADY = rst & (~en_sel | (occ[sel] != 2'd2));
        accept   = s_TVALID & s_TREADY;
        for (int unsigned n = 0; n < 4; n++) begin
            vld[n]  = (occ[n] != 2'd0);
            pop[n]  = vld[n] & o_rdy[n];
            push[n] = accept & en_sel & (sel == 2'(n));
            head[n] = mem[n][rd_ptr[n]];
        end
    end

    always_comb begin
        state_nx = state;
        if (TLAST_ARB != 0 && accept) begin
            case (state)
                IDLE:    if (!s_TLAST) state_nx = LOCKED;
                LOCKED:  if (s_TLAST)  state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            dest_r <= '0;
`ifdef DM4_ROUTE_DROP_EN
            en_r   <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (state == IDLE && accept) begin
                dest_r <= s_TDEST;
`ifdef DM4_ROUTE_DROP_EN
                en_r   <= en[s_TDEST];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned n = 0; n < 4; n++) begin
                occ[n]    <= '0;
                mem[n][0] <= '0;
                mem[n][1] <= '0;
            end
        end else begin
            for (int unsigned n = 0; n < 4; n++) begin
                if (push[n]) begin
                    mem[n][wr_ptr[n]] <= {s_TLAST, s_TDATA};
                    wr_ptr[n]         <= ~wr_ptr[n];
                end
                if (pop[n]) rd_ptr[n] <= ~rd_ptr[n];
                case ({push[n], pop[n]})
                    2'b10:   occ[n] <= occ[n] + 2'd1;
                    2'b01:   occ[n] <= occ[n] - 2'd1;
                    default: occ[n] <= occ[n];
                endcase
            end
        end
    end

`ifdef DM4_ROUTE_DROP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            drop_cnt <= '0;
        else if (accept && !en_sel && s_TLAST && drop_cnt != '1)
            drop_cnt <= drop_cnt + 16'd1;
    end
`endif

    assign o0_TVALID = vld[0];
    assign o0_TDATA  = head[0][DATA_WIDTH-1:0];
    assign o0_TLAST  = head[0][DATA_WIDTH];
    assign o1_TVALID = vld[1];
    assign o1_TDATA  = head[1][DATA_WIDTH-1:0];
    assign o1_TLAST  = head[1][DATA_WIDTH];
    assign o2_TVALID = vld[2];
    assign o2_TDATA  = head[2][DATA_WIDTH-1:0];
    assign o2_TLAST  = head[2][DATA_WIDTH];
    assign o3_TVALID = vld[3];
    assign o3_TDATA  = head[3][DATA_WIDTH-1:0];
    assign o3_TLAST  = head[3][DATA_WIDTH];

endmodule

// File: tb/tb_dm4_route.sv
// Bench for dm4_route: two instances (TLAST_ARB=1 and 0) share stimulus; each is checked
// cycle by cycle against a queue-based reference model. Honors DM4_ROUTE_DROP_EN when defined.
module tb_dm4_route;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] sdata = '0;
    logic        sv = 1'b0, slast = 1'b0;
    logic [1:0]  sd = '0;
    logic [3:0]  ordy = '0;
    logic [3:0]  en = 4'hF;
    logic [1:0]  srdy;
    logic [1:0][3:0]       tv, tl;
    logic [1:0][3:0][31:0] td;
    logic [1:0][15:0]      dc;

    int n_cmp = 0, n_bad = 0, cnt_o0 = 0;

    // Reference model: queue per DUT per output holds exactly the flits the output FIFO owns.
    logic [32:0]  q [2][4][$];
    bit           mlock [2];
    logic [1:0]   mdest [2];
    bit           men   [2];
    int unsigned  mdrop [2];
    bit           acc   [2];

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    dm4_route #(.DATA_WIDTH(32), .TLAST_ARB(1)) u_arb1 (
        .clk(clk), .rst(rst),
`ifdef DM4_ROUTE_DROP_EN
        .en(en), .drop_cnt(dc[0]),
`endif
        .s_TDATA(sdata), .s_TVALID(sv), .s_TREADY(srdy[0]), .s_TLAST(slast), .s_TDEST(sd),
        .o0_TDATA(td[0][0]), .o0_TVALID(tv[0][0]), .o0_TREADY(ordy[0]), .o0_TLAST(tl[0][0]),
        .o1_TDATA(td[0][1]), .o1_TVALID(tv[0][1]), .o1_TREADY(ordy[1]), .o1_TLAST(tl[0][1]),
        .o2_TDATA(td[0][2]), .o2_TVALID(tv[0][2]), .o2_TREADY(ordy[2]), .o2_TLAST(tl[0][2]),
        .o3_TDATA(td[0][3]), .o3_TVALID(tv[0][3]), .o3_TREADY(ordy[3]), .o3_TLAST(tl[0][3])
    );

    dm4_route #(.DATA_WIDTH(32), .TLAST_ARB(0)) u_arb0 (
        .clk(clk), .rst(rst),
`ifdef DM4_ROUTE_DROP_EN
        .en(en), .drop_cnt(dc[1]),
`endif
        .s_TDATA(sdata), .s_TVALID(sv), .s_TREADY(srdy[1]), .s_TLAST(slast), .s_TDEST(sd),
        .o0_TDATA(td[1][0]), .o0_TVALID(tv[1][0]), .o0_TREADY(ordy[0]), .o0_TLAST(tl[1][0]),
        .o1_TDATA(td[1][1]), .o1_TVALID(tv[1][1]), .o1_TREADY(ordy[1]), .o1_TLAST(tl[1][1]),
        .o2_TDATA(td[1][2]), .o2_TVALID(tv[1][2]), .o2_TREADY(ordy[2]), .o2_TLAST(tl[1][2]),
        .o3_TDATA(td[1][3]), .o3_TVALID(tv[1][3]), .o3_TREADY(ordy[3]), .o3_TLAST(tl[1][3])
    );

`ifndef DM4_ROUTE_DROP_EN
    assign dc = '0;
`endif

    task automatic check(input string tag, input int k, input int n,
                         input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s[%0d][%0d]: observed %h expected %h", tag, k, n, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 4; n++) q[k][n].delete();
            mlock[k] = 0; mdest[k] = '0; men[k] = 0; mdrop[k] = 0; acc[k] = 0;
        end
    endtask

    // One clock: compare DUT against model mid-cycle, advance model, move to just after the edge.
    task automatic step();
        #1;
        for (int k = 0; k < 2; k++) begin
            logic [1:0] s;
            bit e, r;
            s = mlock[k] ? mdest[k] : sd;
            e = mlock[k] ? men[k] : en[sd];
            r = rst && (!e || q[k][s].size() < 2);
            check("s_TREADY", k, 0, 64'(srdy[k]), 64'(r));
            for (int n = 0; n < 4; n++) begin
                check("TVALID", k, n, 64'(tv[k][n]), 64'(q[k][n].size() > 0));
                if (q[k][n].size() > 0)
                    check("TLAST_TDATA", k, n, {31'd0, tl[k][n], td[k][n]}, 64'(q[k][n][0]));
            end
`ifdef DM4_ROUTE_DROP_EN
            check("drop_cnt", k, 0, 64'(dc[k]), 64'(mdrop[k]));
`endif
            acc[k] = sv && r;
            if (k == 1 && tv[1][0] && ordy[0]) cnt_o0++;
            if (rst) begin
                for (int n = 0; n < 4; n++)
                    if (ordy[n] && q[k][n].size() > 0) void'(q[k][n].pop_front());
                if (acc[k]) begin
                    if (e) q[k][s].push_back({slast, sdata});
                    else if (slast && mdrop[k] != 32'hFFFF) mdrop[k]++;
                    if (k == 0) begin
                        if (!mlock[k] && !slast) begin
                            mlock[k] = 1; mdest[k] = sd; men[k] = en[sd];
                        end else if (mlock[k] && slast) mlock[k] = 0;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] d, input logic l, input int maxw);
        sv = 1'b1; sd = d; slast = l; sdata = $urandom;
        for (int i = 0; i < maxw; i++) begin
            step();
            if (acc[0]) break;
        end
        check("send_accepted", 0, int'(d), 64'(acc[0]), 64'd1);
        sv = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #1;
        check("rst_valid", 0, 0, 64'({tv[1], tv[0]}), 64'd0);
        check("rst_ready", 0, 0, 64'(srdy), 64'd0);
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        model_reset();
        ordy = 4'hF;
        @(posedge clk);
        #1;
        do_reset();

        // 3-flit packet: dest 2 on the head, dest 0 on the rest, all land on o2 for ARB=1
        send(2'd2, 1'b0, 4);
        check("o2_first_N+1", 0, 2, 64'(tv[0][2]), 64'd1);
        send(2'd0, 1'b0, 4);
        send(2'd0, 1'b1, 4);
        check("o2_last", 0, 2, 64'({tv[0][2], tl[0][2]}), 64'b11);
        check("o0_untouched", 0, 0, 64'(tv[0][0]), 64'd0);
        repeat (3) step();

        // o1 blocked: two single-flit packets fill it, the third stalls the input
        ordy = 4'b1101;
        send(2'd1, 1'b1, 4);
        send(2'd1, 1'b1, 4);
        sv = 1'b1; sd = 2'd1; slast = 1'b1; sdata = $urandom;
        repeat (3) step();
        check("stall_ready", 0, 1, 64'(srdy[0]), 64'd0);
        check("stall_o3_idle", 0, 3, 64'(tv[0][3]), 64'd0);
        ordy = 4'hF;
        send(2'd1, 1'b1, 8);
        send(2'd1, 1'b1, 8);
        send(2'd3, 1'b1, 8);
        repeat (4) step();

        // 100 back-to-back flits to o0
        cnt_o0 = 0;
        for (int i = 0; i < 100; i++) begin
            sv = 1'b1; sd = 2'd0; slast = 1'($urandom); sdata = 32'(i);
            step();
        end
        sv = 1'b0;
        step();
        step();
        check("o0_count", 1, 0, 64'(cnt_o0), 64'd100);

        // alternating 0/3 without TLAST
        for (int i = 0; i < 8; i++) begin
            sv = 1'b1; sd = (i % 2 == 1) ? 2'd3 : 2'd0; slast = 1'b0; sdata = $urandom;
            step();
        end
        check("alt_o3_arb0", 1, 3, 64'(tv[1][3]), 64'd1);
        check("alt_o3_arb1", 0, 3, 64'(tv[0][3]), 64'd0);
        send(2'd0, 1'b1, 4);
        repeat (3) step();

        // reset mid-packet with two flits buffered on o1
        ordy = 4'h0;
        send(2'd1, 1'b0, 4);
        send(2'd1, 1'b0, 4);
        check("buffered", 0, 1, 64'(tv[0][1]), 64'd1);
        do_reset();
        ordy = 4'hF;
        send(2'd2, 1'b1, 4);
        check("post_rst_o2", 0, 2, 64'(tv[0][2]), 64'd1);
        check("post_rst_o1", 0, 1, 64'(tv[0][1]), 64'd0);
        step();

`ifdef DM4_ROUTE_DROP_EN
        do_reset();
        en = 4'b1011;
        sv = 1'b1; sd = 2'd2; slast = 1'b0; sdata = $urandom;
        #1;
        check("drop_ready0", 0, 2, 64'(srdy), 64'b11);
        step();
        slast = 1'b1; sd = 2'd0;
        #1;
        check("drop_ready1", 0, 2, 64'(srdy[0]), 64'd1);
        step();
        sv = 1'b0;
        step();
        check("drop_cnt_1", 0, 2, 64'(dc[0]), 64'd1);
        check("drop_o2_idle", 0, 2, 64'(tv[0][2]), 64'd0);
        en = 4'hF;
`endif

        // randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            sv = 1'($urandom); sd = 2'($urandom); slast = 1'($urandom);
            sdata = $urandom; ordy = 4'($urandom);
`ifdef DM4_ROUTE_DROP_EN
            en = 4'($urandom) | 4'b0001;
`endif
            step();
        end
        sv = 1'b0; ordy = 4'hF;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dm4_route.md
DM4_ROUTE -- requirements
Module: dm4_route

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 32, setting the width of every TDATA field.
REQ-002 The block SHALL expose parameter TLAST_ARB, default 1; 1 holds the route for a whole packet, 0 routes every flit independently.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, reset; it is asynchronous and active-low.
REQ-005 The block SHALL have ports s_TDATA (in, DATA_WIDTH), s_TVALID (in, 1), s_TREADY (out, 1) and s_TLAST (in, 1), the single input stream.
REQ-006 The block SHALL have port s_TDEST, input, 2 bits, the destination index 0..3 for the current flit.
REQ-007 The block SHALL have, for each n in 0..3, ports on_TDATA (out, DATA_WIDTH), on_TVALID (out, 1), on_TREADY (in, 1) and on_TLAST (out, 1), the four output streams.

Function
REQ-008 A flit SHALL transfer on any interface in a cycle where its TVALID and TREADY are both high.
REQ-009 Each output SHALL own a 2-entry FIFO holding {TDATA,TLAST}; on_TVALID and on_TDATA/TLAST SHALL come from registers only.
REQ-010 s_TREADY SHALL equal (selected FIFO occupancy < 2) and SHALL have no combinational path from any on_TREADY or from s_TVALID.
REQ-011 The selected destination SHALL be s_TDEST in state IDLE, and dest_r in state LOCKED.
REQ-012 With TLAST_ARB=1: from IDLE, an input flit with s_TLAST=0 SHALL go to LOCKED with dest_r <= s_TDEST; an input flit with s_TLAST=1 SHALL stay IDLE.
REQ-013 With TLAST_ARB=1: in LOCKED, s_TDEST SHALL be ignored; an input flit with s_TLAST=1 SHALL return the state to IDLE.
REQ-014 With TLAST_ARB=0, the state SHALL remain IDLE permanently, and s_TLAST SHALL be forwarded but not interpreted.
REQ-015 A flit accepted at cycle N SHALL appear on the selected output at cycle N+1; minimum latency 1 cycle.
REQ-016 Each output SHALL sustain one flit per cycle when on_TREADY stays high.
REQ-017 A push and a pop on the same FIFO in the same cycle SHALL leave occupancy unchanged.
REQ-018 Order SHALL be preserved per output, and flits SHALL never be duplicated or lost.
REQ-019 A full destination FIFO SHALL stall only the input; other outputs SHALL keep draining independently.
REQ-020 Changing s_TDEST while s_TVALID is high and unaccepted SHALL be tolerated; the route is taken from the value at the transfer cycle (IDLE only).

Reset
REQ-021 While rst=0, the block SHALL hold state IDLE, dest_r=0, all FIFOs empty, all on_TVALID=0 and s_TREADY=0, regardless of clk.
REQ-022 Reset asserted mid-packet SHALL discard all buffered flits and any lock.
REQ-023 After rst deasserts, the first clock edge SHALL see s_TREADY=1.

Configuration
REQ-024 Macro DM4_ROUTE_DROP_EN, when defined, SHALL add input en[3:0] and output drop_cnt[15:0].
REQ-025 With DM4_ROUTE_DROP_EN defined, flits routed to an output whose en bit is 0 SHALL be accepted (s_TREADY=1) and discarded.
REQ-026 With DM4_ROUTE_DROP_EN defined, en SHALL be sampled with the route: at IDLE transfer, held for the packet when locked.
REQ-027 With DM4_ROUTE_DROP_EN defined, drop_cnt SHALL increment on each discarded flit with TLAST=1, saturating at 16'hFFFF and resetting to 0.
REQ-028 Without DM4_ROUTE_DROP_EN, en and drop_cnt SHALL be absent and all outputs SHALL behave as enabled.

Verification
REQ-029 Bench SHALL cover: 3-flit packet, TDEST=2 on first flit then TDEST=0 -> all 3 on o2, last with o2_TLAST=1, first at N+1.
REQ-030 Bench SHALL cover: o1_TREADY=0, 4 single-flit packets to dest 1 -> s_TREADY drops after 2 accepts; a 5th packet to dest 3 is not accepted until o1 drains.
REQ-031 Bench SHALL cover: o0_TREADY=1, 100 back-to-back flits TDEST=0, TLAST_ARB=0 -> 100 o0 flits on consecutive cycles, data in order.
REQ-032 Bench SHALL cover: TLAST_ARB=0, flits alternating TDEST 0,3 with s_TLAST=0 -> they alternate between o0 and o3.
REQ-033 Bench SHALL cover: rst pulsed low mid-packet with 2 buffered flits -> all on_TVALID=0 immediately, next packet routed by its own TDEST.
REQ-034 Bench SHALL cover, with DM4_ROUTE_DROP_EN: en=4'b1011, 2-flit packet to dest 2 -> no o2 activity, s_TREADY=1 both cycles, drop_cnt 0->1.
